switch_port: RTL and testbench

//  Ingress port of the 16-port packet switch. Accepts a framed 16-bit word stream
//  (sop / control word / data words / eop) and stores each packet in a local buffer.

---
 rtl/switch_port.sv | 229 ++++++++++++++++++++++
 tb/tb_switch_port.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port.sv
// ---------------------------------------------------------------------------
// switch_port
//   Ingress port of the 16-port packet switch. Framed 16-bit words
//   (sop / control word / payload / eop) are stored in a circular buffer.
//   Each complete packet is then replayed to the switch core as one
//   contiguous data_vld burst, tagged with its destination port and length.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   wr_sop     in   start-of-packet pulse, one cycle before the control word
//   wr_eop     in   end-of-packet pulse, one cycle after the last payload word
//   wr_vld     in   qualifies wr_data; may drop low inside a packet
//   wr_data    in   control word ([15:7] len, [6:4] prio, [3:0] dest), payload
//   xfer_stop  in   core backpressure, 1 = halt output
//   dest_port  out  destination of the packet being output
//   data       out  payload word (0 when data_vld is low)
//   data_vld   out  data holds a valid payload word
//   length     out  payload word count of the packet being output
//
// Input FSM
//   state   | meaning
//   IN_IDLE | waiting for wr_sop
//   IN_CTRL | waiting for the control word (first wr_vld word)
//   IN_DATA | storing payload until wr_eop
// Output FSM
//   state    | meaning
//   OUT_IDLE | waiting for a committed descriptor
//   OUT_SEND | streaming the loaded packet out of the buffer
// ---------------------------------------------------------------------------
module switch_port #(
  parameter int DATA_W  = 16,
  parameter int BUF_DEP = 512,
  parameter int PKT_Q   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              xfer_stop,
  output logic [3:0]        dest_port,
  output logic [DATA_W-1:0] data,
  output logic              data_vld,
  output logic [8:0]        length
);

  localparam int AW = $clog2(BUF_DEP);
  localparam int QW = $clog2(PKT_Q);
  localparam logic [8:0]    LEN_MAX = '1;
  localparam logic [AW:0]   PTR_ONE = 1;
  localparam logic [QW:0]   QP_ONE  = 1;
  localparam logic [QW+1:0] Q_DEP   = (QW+2)'(PKT_Q);

  typedef enum logic [1:0] {IN_IDLE, IN_CTRL, IN_DATA} in_state_t;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, wr_cmt, rd_ptr;
  logic [QW:0] q_wp, q_rp;
  logic [8:0]  cnt;
  logic [3:0]  cur_dest;
  logic        drop;
  logic [8:0]  rem;

  logic [DATA_W-1:0] mem [BUF_DEP];
  logic [3:0]        q_dest [PKT_Q];
  logic [8:0]        q_len [PKT_Q];
  logic [DATA_W-1:0] rd_word;

  logic          buf_full;
  logic [QW:0]   q_used;
  logic [QW+1:0] q_occ;
  logic          sop_full;
  logic          push, wr_en, rewind, start, latch_ctrl, set_drop;
  logic          load, rd_en, pop;

  assign buf_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign q_used   = q_wp - q_rp;
  // A sop coinciding with an eop sees the descriptor being committed that cycle.
  assign q_occ    = {1'b0, q_used} + (QW+2)'(push);
  assign sop_full = (q_occ >= Q_DEP);

  always_comb begin
    in_next    = in_state;
    push       = 1'b0;
    wr_en      = 1'b0;
    rewind     = 1'b0;
    start      = 1'b0;
    latch_ctrl = 1'b0;
    set_drop   = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (wr_sop) begin
          start   = 1'b1;
          in_next = IN_CTRL;
        end
      end
      IN_CTRL: begin
        if (wr_sop) begin
          start  = 1'b1;
          rewind = 1'b1;
        end else if (wr_vld) begin
          latch_ctrl = 1'b1;
          in_next    = IN_DATA;
        end
      end
      IN_DATA: begin
        if (wr_eop) begin
          if (drop) rewind = 1'b1;
          else      push   = 1'b1;
          in_next = IN_IDLE;
          if (wr_sop) begin
            start   = 1'b1;
            in_next = IN_CTRL;
          end
        end else if (wr_sop) begin
          rewind  = 1'b1;
          start   = 1'b1;
          in_next = IN_CTRL;
        end else if (wr_vld && !drop) begin
          if (buf_full)            set_drop = 1'b1;
          else if (cnt != LEN_MAX) wr_en    = 1'b1;
        end
      end
      default: in_next = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state <= IN_IDLE;
      wr_ptr   <= '0;
      wr_cmt   <= '0;
      q_wp     <= '0;
      cnt      <= '0;
      cur_dest <= '0;
      drop     <= 1'b0;
    end else begin
      in_state <= in_next;
      if (latch_ctrl) cur_dest <= wr_data[3:0];
      if (start) begin
        cnt  <= '0;
        drop <= sop_full;
      end else begin
        if (set_drop) drop <= 1'b1;
        if (wr_en)    cnt  <= cnt + 9'd1;
      end
      if (wr_en)       wr_ptr <= wr_ptr + PTR_ONE;
      else if (rewind) wr_ptr <= wr_cmt;
      if (push) begin
        wr_cmt <= wr_ptr;
        q_wp   <= q_wp + QP_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    if (rd_en) rd_word <= mem[rd_ptr[AW-1:0]];
    if (push) begin
      q_dest[q_wp[QW-1:0]] <= cur_dest;
      q_len[q_wp[QW-1:0]]  <= cnt;
    end
  end

  always_comb begin
    out_next = out_state;
    load     = 1'b0;
    rd_en    = 1'b0;
    pop      = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (q_used != '0) begin
          load     = 1'b1;
          out_next = OUT_SEND;
        end
      end
      OUT_SEND: begin
        if (rem == 9'd0) begin
          pop      = 1'b1;
          out_next = OUT_IDLE;
        end else if (!xfer_stop) begin
          rd_en = 1'b1;
          // Pop together with the last read so the next packet loads sooner.
          if (rem == 9'd1) begin
            pop      = 1'b1;
            out_next = OUT_IDLE;
          end
        end
      end
      default: out_next = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= OUT_IDLE;
      rd_ptr    <= '0;
      q_rp      <= '0;
      rem       <= '0;
      dest_port <= '0;
      length    <= '0;
      data_vld  <= 1'b0;
    end else begin
      out_state <= out_next;
      data_vld  <= rd_en;
      if (load) begin
        dest_port <= q_dest[q_rp[QW-1:0]];
        length    <= q_len[q_rp[QW-1:0]];
        rem       <= q_len[q_rp[QW-1:0]];
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rem    <= rem - 9'd1;
      end
      if (pop) q_rp <= q_rp + QP_ONE;
    end
  end

  // The read register has no reset; gating keeps data at 0 outside bursts.
  assign data = data_vld ? rd_word : '0;

endmodule

// File: tb/tb_switch_port.sv
module tb_switch_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_sop = 1'b0, wr_eop = 1'b0, wr_vld = 1'b0, xfer_stop = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  dest_port;
  logic [15:0] data;
  logic        data_vld;
  logic [8:0]  length;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  switch_port dut (
    .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_eop(wr_eop),
    .wr_vld(wr_vld), .wr_data(wr_data), .xfer_stop(xfer_stop),
    .dest_port(dest_port), .data(data), .data_vld(data_vld), .length(length)
  );

  // Reference model: the committed packets in order, as the core must see them.
  logic [15:0] exp_words[$];
  int          exp_len[$];
  int          exp_dest[$];
  int          committed = 0;
  int          done = 0;
  int          word_in_pkt = 0;
  bit          mon_en = 1'b0;
  bit          rnd_stop_en = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en && data_vld) begin
      chk("pending_pkt", int'(exp_len.size() > 0), 1);
      if (exp_len.size() > 0) begin
        chk("data", int'(data), int'(exp_words.pop_front()));
        chk("dest", int'(dest_port), exp_dest[0]);
        chk("length", int'(length), exp_len[0]);
        word_in_pkt++;
        if (word_in_pkt == exp_len[0]) begin
          void'(exp_len.pop_front());
          void'(exp_dest.pop_front());
          word_in_pkt = 0;
          done++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_stop_en) xfer_stop = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int dest, input int len, input int base,
                          input int gap_mode, input int pri, input bit skip_sop,
                          input int abort_at, input bit want_join,
                          output bit joined);
    logic [15:0] words[$];
    logic [8:0]  l9;
    logic [2:0]  p3;
    logic [3:0]  d4;
    l9 = 9'(len);
    p3 = 3'(pri);
    d4 = 4'(dest);
    joined = 1'b0;
    if (!skip_sop) begin
      wr_sop = 1'b1;
      tick();
      wr_sop = 1'b0;
    end
    wr_vld  = 1'b1;
    wr_data = {l9, p3, d4};
    tick();
    for (int i = 0; i < len; i++) begin
      if (abort_at == i) begin
        wr_vld = 1'b0;
        return;
      end
      if ((gap_mode == 1 && i >= 32 && i <= 74) ||
          (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
        wr_vld  = 1'b0;
        wr_data = 16'($urandom);
        tick();
      end
      wr_vld  = 1'b1;
      wr_data = 16'(base + i);
      words.push_back(wr_data);
      tick();
    end
    wr_vld = 1'b0;
    wr_eop = 1'b1;
    joined = want_join && (committed + 1 - done <= 3);
    wr_sop = joined;
    tick();
    wr_eop = 1'b0;
    wr_sop = 1'b0;
    if (len > 0) begin
      foreach (words[k]) exp_words.push_back(words[k]);
      exp_len.push_back(len);
      exp_dest.push_back(dest);
      committed++;
    end
  endtask

  task automatic wait_room();
    int n = 0;
    while (committed - done > 3 && n < 5000) begin
      tick();
      n++;
    end
    chk("room_timeout", int'(committed - done <= 3), 1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_len.size() != 0 && n < 20000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk(tag, exp_len.size(), 0);
  endtask

  task automatic wait_words(input int w);
    int n = 0;
    while (word_in_pkt < w && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_words", int'(word_in_pkt >= w), 1);
  endtask

  // Latency from the cycle after eop to the first data_vld, then burst run length.
  task automatic measure_burst(output int lat, output int run);
    lat = 0;
    run = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (data_vld) begin
        lat = n;
        break;
      end
    end
    if (lat != 0) begin
      run = 1;
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        if (data_vld) run++;
        else break;
      end
    end
  endtask

  initial begin
    bit joined;
    int lat, run, d0, sum, base;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld", int'(data_vld), 0);
    chk("rst_dest", int'(dest_port), 0);
    chk("rst_len", int'(length), 0);
    chk("rst_data", int'(data), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // 1: 128-word packet, control word 16'h4035
    send_pkt(5, 128, 0, 0, 3, 1'b0, -1, 1'b0, joined);
    measure_burst(lat, run);
    chk("t1_latency", lat, 3);
    chk("t1_burst", run, 128);
    chk("t1_dest", int'(dest_port), 5);
    chk("t1_len", int'(length), 128);
    wait_drain("t1_drain");

    // 2: same packet with idle gaps inside words 32..74
    send_pkt(5, 128, 0, 1, 3, 1'b0, -1, 1'b0, joined);
    measure_burst(lat, run);
    chk("t2_latency", lat, 3);
    chk("t2_burst", run, 128);
    wait_drain("t2_drain");

    // 3: 10-cycle stall mid-burst
    send_pkt(6, 128, 1000, 0, 0, 1'b0, -1, 1'b0, joined);
    wait_words(20);
    @(posedge clk);
    #1 xfer_stop = 1'b1;
    tick();
    sum = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sum += int'(data_vld);
      tick();
      if (i == 8) xfer_stop = 1'b0;
    end
    @(negedge clk);
    chk("t3_stall_vld", sum, 0);
    chk("t3_resume_vld", int'(data_vld), 1);
    wait_drain("t3_drain");

    // 4: back-to-back packets, eop->sop gap of 3 cycles
    d0 = done;
    send_pkt(3, 20, 2000, 0, 1, 1'b0, -1, 1'b0, joined);
    repeat (3) tick();
    send_pkt(9, 15, 3000, 0, 2, 1'b0, -1, 1'b0, joined);
    wait_drain("t4_drain");
    chk("t4_pkts", done - d0, 2);

    // 5: sop mid-packet discards the first packet
    d0 = done;
    send_pkt(7, 10, 4000, 0, 0, 1'b0, 6, 1'b0, joined);
    send_pkt(2, 12, 5000, 0, 0, 1'b0, -1, 1'b0, joined);
    wait_drain("t5_drain");
    chk("t5_pkts", done - d0, 1);

    // zero-length packet: descriptor loads with length 0, no data
    send_pkt(10, 0, 0, 0, 0, 1'b0, -1, 1'b0, joined);
    @(negedge clk);
    @(negedge clk);
    chk("zl_len", int'(length), 0);
    chk("zl_dest", int'(dest_port), 10);
    send_pkt(11, 4, 6000, 0, 0, 1'b0, -1, 1'b0, joined);
    wait_drain("zl_drain");

    // descriptor queue full at sop: fifth packet is dropped
    d0 = done;
    xfer_stop = 1'b1;
    for (int p = 0; p < 4; p++) begin
      send_pkt(p + 1, 5, 7000 + 10 * p, 0, 0, 1'b0, -1, 1'b0, joined);
      tick();
    end
    wr_sop = 1'b1;
    tick();
    wr_sop = 1'b0;
    wr_vld = 1'b1;
    wr_data = 16'h028F;
    tick();
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'(7500 + i);
      tick();
    end
    wr_vld = 1'b0;
    wr_eop = 1'b1;
    tick();
    wr_eop = 1'b0;
    xfer_stop = 1'b0;
    wait_drain("qf_drain");
    chk("qf_pkts", done - d0, 4);

    // randomized traffic with random backpressure, aborts and sop+eop joins
    rnd_stop_en = 1'b1;
    joined = 1'b0;
    base = 10000;
    for (int p = 0; p < 40; p++) begin
      int len, ab;
      bit last, jn;
      last = (p == 39);
      len = $urandom_range(1, 40);
      ab = (!last && $urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
      jn = !last && ($urandom_range(0, 6) == 0);
      if (!joined) wait_room();
      send_pkt($urandom_range(0, 15), len, base, 2, $urandom_range(0, 7),
               joined, ab, jn, joined);
      if (!joined) repeat ($urandom_range(0, 3)) tick();
      base += len;
    end
    tick();
    rnd_stop_en = 1'b0;
    xfer_stop = 1'b0;
    wait_drain("rnd_drain");

    // 6: reset during an output burst
    send_pkt(4, 100, 20000, 0, 0, 1'b0, -1, 1'b0, joined);
    wait_words(10);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", int'(data_vld), 0);
    chk("t6_rst_dest", int'(dest_port), 0);
    chk("t6_rst_len", int'(length), 0);
    exp_words.delete();
    exp_len.delete();
    exp_dest.delete();
    word_in_pkt = 0;
    committed = 0;
    done = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    sum = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sum += int'(data_vld);
    end
    chk("t6_empty", sum, 0);
    mon_en = 1'b1;
    tick();
    send_pkt(12, 8, 30000, 0, 0, 1'b0, -1, 1'b0, joined);
    measure_burst(lat, run);
    chk("t6_latency", lat, 3);
    chk("t6_burst", run, 8);
    wait_drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
